// File: rtl/zxuno_regport.sv
// ZX-Uno register port: an address port selects an internal register number,
// and a data port signals reads and writes of the selected register.
// Writes are edge-detected, so each CPU write cycle produces one load or strobe.
module zxuno_regport #(
  parameter logic [15:0] ADDR_PORT = 16'hFC3B,
  parameter logic [15:0] DATA_PORT = 16'hFD3B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe_n,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic        regaddr_changed,
  output logic        regwr_stb
);

  logic addr_wr;
  logic addr_rd;
  logic data_wr;
  logic data_rd;
  logic aw_q;
  logic dw_q;
  logic addr_wr_edge;
  logic data_wr_edge;

  // Bus decode; requiring the opposite strobe high rejects the illegal rd_n=wr_n=0 state.
  always_comb begin
    addr_wr = !iorq_n && !wr_n &&  rd_n && (a == ADDR_PORT);
    addr_rd = !iorq_n && !rd_n &&  wr_n && (a == ADDR_PORT);
    data_wr = !iorq_n && !wr_n &&  rd_n && (a == DATA_PORT);
    data_rd = !iorq_n && !rd_n &&  wr_n && (a == DATA_PORT);
    addr_wr_edge = addr_wr && !aw_q;
    data_wr_edge = data_wr && !dw_q;
  end

  // Zero-latency status outputs and address read-back driven only while selected.
  assign zxuno_regrd = data_rd;
  assign zxuno_regwr = data_wr;
  assign oe_n        = !addr_rd;
  assign dout        = oe_n ? 8'hzz : zxuno_addr;

  // Edge history, register load and one-clk pulses. The history resets to 1 so a
  // write already in progress when reset releases is not taken as a new write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_q            <= 1'b1;
      dw_q            <= 1'b1;
      zxuno_addr      <= 8'h00;
      regaddr_changed <= 1'b0;
      regwr_stb       <= 1'b0;
    end else begin
      aw_q            <= addr_wr;
      dw_q            <= data_wr;
      regaddr_changed <= addr_wr_edge;
      regwr_stb       <= data_wr_edge;
      if (addr_wr_edge) begin
        zxuno_addr <= din;
      end
    end
  end

endmodule

// File: tb/tb_zxuno_regport.sv
// Self-checking bench for zxuno_regport: directed scenarios followed by
// randomized bus cycles, all compared against a transaction-level model.
module tb_zxuno_regport;

  localparam logic [15:0] AP = 16'hFC3B;
  localparam logic [15:0] DP = 16'hFD3B;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  din;
  wire  [7:0]  dout;
  logic        oe_n;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regrd;
  logic        zxuno_regwr;
  logic        regaddr_changed;
  logic        regwr_stb;

  int checks = 0;
  int failures = 0;

  // Model state: selected register, pending one-clk pulses, and whether the
  // current CPU write cycle to each port has already been acted upon.
  logic [7:0] m_reg;
  logic       m_chg;
  logic       m_stb;
  logic       m_addr_cycle_done;
  logic       m_data_cycle_done;
  int         chg_seen;
  int         stb_seen;
  int         rd_seen;

  zxuno_regport #(.ADDR_PORT(AP), .DATA_PORT(DP)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .din(din), .dout(dout), .oe_n(oe_n), .zxuno_addr(zxuno_addr),
    .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
    .regaddr_changed(regaddr_changed), .regwr_stb(regwr_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_out(input logic [15:0] port);
    return !iorq_n && !wr_n && rd_n && (a == port);
  endfunction

  function automatic logic is_in(input logic [15:0] port);
    return !iorq_n && !rd_n && wr_n && (a == port);
  endfunction

  // Compare every output against the model, away from the active edge.
  task automatic check_outputs();
    chk("regrd", {15'd0, zxuno_regrd}, {15'd0, is_in(DP)});
    chk("regwr", {15'd0, zxuno_regwr}, {15'd0, is_out(DP)});
    chk("oe_n", {15'd0, oe_n}, {15'd0, !is_in(AP)});
    chk("zxuno_addr", {8'd0, zxuno_addr}, {8'd0, m_reg});
    chk("regaddr_changed", {15'd0, regaddr_changed}, {15'd0, m_chg});
    chk("regwr_stb", {15'd0, regwr_stb}, {15'd0, m_stb});
    if (is_in(AP)) chk("dout", {8'd0, dout}, {8'd0, m_reg});
    if (regaddr_changed) chg_seen++;
    if (regwr_stb) stb_seen++;
    if (zxuno_regrd) rd_seen++;
  endtask

  // Model reaction at a clock edge: a write cycle acts once, at its first edge.
  task automatic model_edge();
    if (!rst_n) begin
      m_reg = 8'h00;
      m_chg = 1'b0;
      m_stb = 1'b0;
      m_addr_cycle_done = 1'b1;
      m_data_cycle_done = 1'b1;
    end else begin
      m_chg = is_out(AP) && !m_addr_cycle_done;
      m_stb = is_out(DP) && !m_data_cycle_done;
      if (m_chg) m_reg = din;
      m_addr_cycle_done = is_out(AP);
      m_data_cycle_done = is_out(DP);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] aa, input logic iq,
                      input logic rr, input logic ww, input logic [7:0] d);
    rst_n = r; a = aa; iorq_n = iq; rd_n = rr; wr_n = ww; din = d;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; a = 16'h0000; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; din = 8'h00;
    @(posedge clk);
    model_edge();
    #1;
    step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h00);
    chk("reset_addr", {8'd0, zxuno_addr}, 16'h0000);
    idle(1);

    // Address write held 3 clks: one load, one pulse.
    chg_seen = 0;
    for (int i = 0; i < 3; i++) step(1'b1, AP, 1'b0, 1'b1, 1'b0, 8'hFF);
    idle(2);
    chk("aw_hold_pulses", 16'(chg_seen), 16'd1);
    chk("aw_hold_value", {8'd0, zxuno_addr}, 16'h00FF);

    // Same value twice with an idle clk between: two pulses.
    chg_seen = 0;
    step(1'b1, AP, 1'b0, 1'b1, 1'b0, 8'hFF);
    idle(1);
    step(1'b1, AP, 1'b0, 1'b1, 1'b0, 8'hFF);
    idle(2);
    chk("aw_same_pulses", 16'(chg_seen), 16'd2);

    // Mid-cycle din change ignored.
    step(1'b1, AP, 1'b0, 1'b1, 1'b0, 8'h3C);
    step(1'b1, AP, 1'b0, 1'b1, 1'b0, 8'h99);
    idle(1);
    chk("aw_midcycle", {8'd0, zxuno_addr}, 16'h003C);

    // Data port read for 4 clks.
    rd_seen = 0;
    for (int i = 0; i < 4; i++) step(1'b1, DP, 1'b0, 1'b0, 1'b1, 8'h55);
    idle(1);
    chk("dr_cycles", 16'(rd_seen), 16'd4);
    chk("dr_addr_kept", {8'd0, zxuno_addr}, 16'h003C);

    // Address read-back.
    for (int i = 0; i < 2; i++) step(1'b1, AP, 1'b0, 1'b0, 1'b1, 8'h00);
    idle(1);

    // Data port write: one strobe, no address pulse.
    chg_seen = 0; stb_seen = 0;
    for (int i = 0; i < 3; i++) step(1'b1, DP, 1'b0, 1'b1, 1'b0, 8'hA5);
    idle(2);
    chk("dw_stb", 16'(stb_seen), 16'd1);
    chk("dw_no_chg", 16'(chg_seen), 16'd0);

    // Reset during a write, released while wr_n still low; then a normal write.
    chg_seen = 0;
    step(1'b1, AP, 1'b0, 1'b1, 1'b0, 8'h77);
    step(1'b0, AP, 1'b0, 1'b1, 1'b0, 8'h77);
    step(1'b1, AP, 1'b0, 1'b1, 1'b0, 8'h77);
    step(1'b1, AP, 1'b0, 1'b1, 1'b0, 8'h77);
    idle(1);
    chk("rst_mid_addr", {8'd0, zxuno_addr}, 16'h0000);
    chk("rst_mid_pulses", 16'(chg_seen), 16'd1);
    step(1'b1, AP, 1'b0, 1'b1, 1'b0, 8'h5A);
    idle(1);
    chk("post_rst_load", {8'd0, zxuno_addr}, 16'h005A);

    // Illegal bus state.
    chg_seen = 0;
    for (int i = 0; i < 2; i++) step(1'b1, AP, 1'b0, 1'b0, 1'b0, 8'h11);
    idle(1);
    chk("illegal_addr", {8'd0, zxuno_addr}, 16'h005A);
    chk("illegal_pulses", 16'(chg_seen), 16'd0);

    // Address changing into ADDR_PORT while wr_n already low.
    step(1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 8'hC3);
    step(1'b1, AP, 1'b0, 1'b1, 1'b0, 8'hC3);
    idle(1);
    chk("enter_port_load", {8'd0, zxuno_addr}, 16'h00C3);

    // Randomized bus cycles.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ra;
      logic [7:0]  rdv;
      logic        riq, rrd, rwr, rrst;
      int          hold;
      case ($urandom_range(0, 3))
        0: ra = AP;
        1: ra = DP;
        2: ra = AP ^ 16'(1 << $urandom_range(0, 15));
        default: ra = 16'($urandom);
      endcase
      riq  = ($urandom_range(0, 4) == 0);
      rrd  = ($urandom_range(0, 2) != 0);
      rwr  = ($urandom_range(0, 2) != 0);
      rrst = ($urandom_range(0, 30) != 0);
      rdv  = 8'($urandom);
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        if ($urandom_range(0, 5) == 0) rdv = 8'($urandom);
        step(rrst, ra, riq, rrd, rwr, rdv);
      end
      if ($urandom_range(0, 2) == 0) idle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global timeout guard.
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
